// File: rtl/pipe_reg_pkg.sv
//------------------------------------------------------------------------------
// pipe_reg_pkg : op codes, header layout and FSM encoding for pipe_reg_master
// Optional build macro: PIPE_REG_MASTER_CHECKSUM_EN (adds the RD_CSUM state)
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package pipe_reg_pkg;

  localparam logic [3:0] OP_WRITE    = 4'h1;
  localparam logic [3:0] OP_READ     = 4'h2;

  localparam int         HDR_OP_LSB  = 28;
  localparam int         HDR_LEN_LSB = 16;
  localparam int         HDR_LEN_W   = 12;
  localparam int         HDR_ADDR_W  = 16;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_DECODE   = 4'd1,
    ST_WR_DATA  = 4'd2,
    ST_RD_ISSUE = 4'd3,
`ifdef PIPE_REG_MASTER_CHECKSUM_EN
    ST_RD_DRAIN = 4'd4,
    ST_RD_CSUM  = 4'd5
`else
    ST_RD_DRAIN = 4'd4
`endif
  } state_t;

  function automatic logic [3:0] hdr_op(input logic [31:0] w);
    return w[HDR_OP_LSB +: 4];
  endfunction

  function automatic logic [HDR_LEN_W-1:0] hdr_len(input logic [31:0] w);
    return w[HDR_LEN_LSB +: HDR_LEN_W];
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_reg_fifo.sv
//------------------------------------------------------------------------------
// pipe_reg_fifo : synchronous first-word-fall-through FIFO, power-of-2 DEPTH
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pipe_reg_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [WIDTH-1:0]           i_data,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int               AW     = $clog2(DEPTH);
  localparam logic [AW:0]      C_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // A pop frees the slot this cycle, so a push is accepted even when full
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == C_FULL);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/pipe_reg_master.sv
//------------------------------------------------------------------------------
// pipe_reg_master : pipe-stream command decoder driving a register-bus target
// Optional build macro: PIPE_REG_MASTER_CHECKSUM_EN (XOR checksum word per READ)
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pipe_reg_master
  import pipe_reg_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int CMD_DEPTH = 16,
  parameter int RSP_DEPTH = 64
) (
  input  logic        okClk,
  input  logic        reset_n,
  input  logic        pipe_in_wr,
  input  logic [31:0] pipe_in_data,
  input  logic        pipe_out_rd,
  output logic [31:0] pipe_out_data,
  output logic        regWrite,
  output logic        regRead,
  output logic [31:0] regAddress,
  output logic [31:0] regWriteData,
  input  logic [31:0] regReadData,
  output logic [31:0] status
);

  localparam int                CMD_CW      = $clog2(CMD_DEPTH) + 1;
  localparam int                RSP_CW      = $clog2(RSP_DEPTH) + 1;
  localparam logic [RSP_CW-1:0] C_RSP_DEPTH = RSP_CW'(RSP_DEPTH);

  state_t                 r_state;
  state_t                 w_next;
  logic [ADDR_W-1:0]      r_addr;
  logic [HDR_LEN_W-1:0]   r_len;
  logic                   r_rd_vld;
  logic                   r_cmd_ovf;
  logic                   r_rsp_unf;
  logic                   r_bad_op;

  logic                   w_rst;
  logic [31:0]            w_cmd_head;
  logic                   w_cmd_full;
  logic                   w_cmd_empty;
  logic [CMD_CW-1:0]      w_cmd_count;
  logic                   w_cmd_push;
  logic                   w_cmd_pop;
  logic [31:0]            w_rsp_head;
  logic [31:0]            w_rsp_din;
  logic                   w_rsp_full;
  logic                   w_rsp_empty;
  logic [RSP_CW-1:0]      w_rsp_count;
  logic                   w_rsp_push;
  logic                   w_rsp_pop;
  logic                   w_rd_room;
  logic                   w_wr_fire;
  logic                   w_rd_fire;
  logic                   w_csum_push;
  logic                   w_busy;

`ifdef PIPE_REG_MASTER_CHECKSUM_EN
  logic [31:0]            r_csum;
`endif

  assign w_rst      = !reset_n;
  assign w_cmd_push = pipe_in_wr && !w_cmd_full;
  assign w_rsp_pop  = pipe_out_rd && !w_rsp_empty;
  // Two free slots: one for the word still in flight, one for this strobe
  assign w_rd_room  = (C_RSP_DEPTH - w_rsp_count) >= RSP_CW'(2);

  pipe_reg_fifo #(.DEPTH(CMD_DEPTH), .WIDTH(32)) u_cmd_fifo (
    .clk     (okClk),
    .rst     (w_rst),
    .i_push  (w_cmd_push),
    .i_pop   (w_cmd_pop),
    .i_data  (pipe_in_data),
    .o_data  (w_cmd_head),
    .o_full  (w_cmd_full),
    .o_empty (w_cmd_empty),
    .o_count (w_cmd_count)
  );

  pipe_reg_fifo #(.DEPTH(RSP_DEPTH), .WIDTH(32)) u_rsp_fifo (
    .clk     (okClk),
    .rst     (w_rst),
    .i_push  (w_rsp_push),
    .i_pop   (w_rsp_pop),
    .i_data  (w_rsp_din),
    .o_data  (w_rsp_head),
    .o_full  (w_rsp_full),
    .o_empty (w_rsp_empty),
    .o_count (w_rsp_count)
  );

  always_ff @(posedge okClk) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:     if (!w_cmd_empty) w_next = ST_DECODE;
      ST_DECODE: begin
        w_next = ST_IDLE;
        if (hdr_len(w_cmd_head) != '0) begin
          if (hdr_op(w_cmd_head) == OP_WRITE)     w_next = ST_WR_DATA;
          else if (hdr_op(w_cmd_head) == OP_READ) w_next = ST_RD_ISSUE;
        end
      end
      ST_WR_DATA:  if (w_wr_fire && r_len == HDR_LEN_W'(1)) w_next = ST_IDLE;
      ST_RD_ISSUE: if (w_rd_fire && r_len == HDR_LEN_W'(1)) w_next = ST_RD_DRAIN;
`ifdef PIPE_REG_MASTER_CHECKSUM_EN
      ST_RD_DRAIN: if (!r_rd_vld) w_next = ST_RD_CSUM;
      ST_RD_CSUM:  if (w_csum_push) w_next = ST_IDLE;
`else
      ST_RD_DRAIN: if (!r_rd_vld) w_next = ST_IDLE;
`endif
      default:     w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_wr_fire   = (r_state == ST_WR_DATA) && !w_cmd_empty;
    w_rd_fire   = (r_state == ST_RD_ISSUE) && w_rd_room;
    w_cmd_pop   = (r_state == ST_DECODE) || w_wr_fire;
`ifdef PIPE_REG_MASTER_CHECKSUM_EN
    w_csum_push = (r_state == ST_RD_CSUM) && !w_rsp_full;
    w_rsp_din   = r_rd_vld ? regReadData : r_csum;
`else
    w_csum_push = 1'b0;
    w_rsp_din   = regReadData;
`endif
    w_rsp_push  = r_rd_vld || w_csum_push;
  end

  always_ff @(posedge okClk) begin
    if (!reset_n) begin
      r_addr    <= '0;
      r_len     <= '0;
      r_rd_vld  <= 1'b0;
      r_cmd_ovf <= 1'b0;
      r_rsp_unf <= 1'b0;
      r_bad_op  <= 1'b0;
    end else begin
      r_rd_vld <= w_rd_fire;
      if (r_state == ST_DECODE) begin
        r_addr <= w_cmd_head[ADDR_W-1:0];
        r_len  <= hdr_len(w_cmd_head);
        if (hdr_op(w_cmd_head) != OP_WRITE && hdr_op(w_cmd_head) != OP_READ)
          r_bad_op <= 1'b1;
      end else if (w_wr_fire || w_rd_fire) begin
        r_addr <= r_addr + 1'b1;
        r_len  <= r_len - 1'b1;
      end
      if (pipe_in_wr && w_cmd_full)   r_cmd_ovf <= 1'b1;
      if (pipe_out_rd && w_rsp_empty) r_rsp_unf <= 1'b1;
    end
  end

`ifdef PIPE_REG_MASTER_CHECKSUM_EN
  always_ff @(posedge okClk) begin
    if (!reset_n)                  r_csum <= '0;
    else if (r_state == ST_DECODE) r_csum <= '0;
    else if (r_rd_vld)             r_csum <= r_csum ^ regReadData;
  end
`endif

  assign w_busy        = (r_state != ST_IDLE) || (w_cmd_count != '0);
  assign regWrite      = w_wr_fire;
  assign regRead       = w_rd_fire;
  assign regAddress    = {{(32-ADDR_W){1'b0}}, r_addr};
  assign regWriteData  = w_wr_fire ? w_cmd_head : 32'h0;
  assign pipe_out_data = w_rsp_empty ? 32'h0 : w_rsp_head;
  assign status        = {{(16-RSP_CW){1'b0}}, w_rsp_count, 8'h00, r_state,
                          r_bad_op, r_rsp_unf, r_cmd_ovf, w_busy};

endmodule

`default_nettype wire

// File: tb/tb_pipe_reg_master.sv
//------------------------------------------------------------------------------
// tb_pipe_reg_master : directed self-checking bench for pipe_reg_master
// Honours PIPE_REG_MASTER_CHECKSUM_EN when defined for the build
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pipe_reg_master;

  logic        okClk        = 1'b0;
  logic        reset_n      = 1'b0;
  logic        pipe_in_wr   = 1'b0;
  logic [31:0] pipe_in_data = 32'h0;
  logic        pipe_out_rd  = 1'b0;
  logic [31:0] regReadData  = 32'h0;
  wire  [31:0] pipe_out_data;
  wire         regWrite;
  wire         regRead;
  wire  [31:0] regAddress;
  wire  [31:0] regWriteData;
  wire  [31:0] status;

  int n_checks = 0;
  int n_err    = 0;
  int both_cnt = 0;

  logic [31:0] wq_a[$];
  logic [31:0] wq_d[$];
  logic [31:0] rq_a[$];
  logic [31:0] exp_mem[1024];
  bit   [31:0] tmem[1024];
  bit          twr[1024];

  always #5 okClk = ~okClk;

  pipe_reg_master dut (
    .okClk         (okClk),
    .reset_n       (reset_n),
    .pipe_in_wr    (pipe_in_wr),
    .pipe_in_data  (pipe_in_data),
    .pipe_out_rd   (pipe_out_rd),
    .pipe_out_data (pipe_out_data),
    .regWrite      (regWrite),
    .regRead       (regRead),
    .regAddress    (regAddress),
    .regWriteData  (regWriteData),
    .regReadData   (regReadData),
    .status        (status)
  );

  function automatic logic [31:0] pat(input int a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  // Register target: block-RAM style, read data one cycle after the strobe
  always @(posedge okClk) begin
    if (regWrite) begin
      tmem[regAddress[9:0]] <= regWriteData;
      twr[regAddress[9:0]]  <= 1'b1;
    end
    if (regRead)
      regReadData <= twr[regAddress[9:0]] ? tmem[regAddress[9:0]] : pat(int'(regAddress[9:0]));
  end

  always @(posedge okClk) begin
    if (reset_n) begin
      if (regWrite) begin
        wq_a.push_back(regAddress);
        wq_d.push_back(regWriteData);
      end
      if (regRead) rq_a.push_back(regAddress);
      if (regWrite && regRead) both_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge okClk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    pipe_in_wr   = 1'b1;
    pipe_in_data = w;
    tick();
    pipe_in_wr   = 1'b0;
  endtask

  task automatic pop_word(output logic [31:0] got);
    got         = pipe_out_data;
    pipe_out_rd = 1'b1;
    tick();
    pipe_out_rd = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (status[0] && n < 3000) begin
      tick();
      n++;
    end
    chk(tag, {31'h0, status[0]}, 32'h0);
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] xs;
    int wb, rb, nbad, n;

    for (int i = 0; i < 1024; i++) exp_mem[i] = pat(i);

    // Reset state
    repeat (3) tick();
    chk("rst_status", status, 32'h0);
    chk("rst_regwrite", {31'h0, regWrite}, 32'h0);
    chk("rst_regread", {31'h0, regRead}, 32'h0);
    chk("rst_pipe_out", pipe_out_data, 32'h0);
    chk("rst_addr", regAddress, 32'h0);
    reset_n = 1'b1;
    tick();

    // WRITE 3 words at 0x10
    wb = wq_a.size();
    push_word(32'h1003_0010);
    push_word(32'hAAAA_0001);
    push_word(32'hBBBB_0002);
    push_word(32'hCCCC_0003);
    wait_idle("wr_idle");
    exp_mem[16'h10] = 32'hAAAA_0001;
    exp_mem[16'h11] = 32'hBBBB_0002;
    exp_mem[16'h12] = 32'hCCCC_0003;
    chk("wr_count", 32'(wq_a.size() - wb), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("wr_addr", wq_a[wb+i], 32'h10 + 32'(i));
      chk("wr_data", wq_d[wb+i], exp_mem[16'h10 + i]);
    end

    // READ them back
    rb = rq_a.size();
    push_word(32'h2003_0010);
    wait_idle("rd_idle");
    chk("rd_strobes", 32'(rq_a.size() - rb), 32'd3);
    for (int i = 0; i < 3; i++) chk("rd_addr", rq_a[rb+i], 32'h10 + 32'(i));
`ifdef PIPE_REG_MASTER_CHECKSUM_EN
    chk("rd_rsp_count", {16'h0, status[31:16]}, 32'd4);
`else
    chk("rd_rsp_count", {16'h0, status[31:16]}, 32'd3);
`endif
    xs = 32'h0;
    for (int i = 0; i < 3; i++) begin
      pop_word(got);
      chk("rd_data", got, exp_mem[16'h10 + i]);
      xs ^= exp_mem[16'h10 + i];
    end
`ifdef PIPE_REG_MASTER_CHECKSUM_EN
    pop_word(got);
    chk("rd_csum", got, xs);
`endif
    chk("rd_rsp_drained", {16'h0, status[31:16]}, 32'd0);

    // Address wrap at 0x3FF
    wb = wq_a.size();
    push_word(32'h1002_03FF);
    push_word(32'h1234_5678);
    push_word(32'h9ABC_DEF0);
    wait_idle("wrap_wr_idle");
    exp_mem[16'h3FF] = 32'h1234_5678;
    exp_mem[0]       = 32'h9ABC_DEF0;
    chk("wrap_wr_addr0", wq_a[wb], 32'h3FF);
    chk("wrap_wr_addr1", wq_a[wb+1], 32'h000);
    rb = rq_a.size();
    push_word(32'h2002_03FF);
    wait_idle("wrap_rd_idle");
    chk("wrap_rd_addr0", rq_a[rb], 32'h3FF);
    chk("wrap_rd_addr1", rq_a[rb+1], 32'h000);
    pop_word(got);
    chk("wrap_data0", got, 32'h1234_5678);
    pop_word(got);
    chk("wrap_data1", got, 32'h9ABC_DEF0);
`ifdef PIPE_REG_MASTER_CHECKSUM_EN
    pop_word(got);
    chk("wrap_csum", got, 32'h1234_5678 ^ 32'h9ABC_DEF0);
`endif

    // Bad op dropped, following header still decoded
    wb = wq_a.size();
    rb = rq_a.size();
    push_word(32'h3001_0000);
    wait_idle("bad_idle");
    chk("bad_op_flag", {31'h0, status[3]}, 32'h1);
    chk("bad_no_strobe", 32'(wq_a.size() - wb + rq_a.size() - rb), 32'd0);
    push_word(32'h1001_0020);
    push_word(32'hD00D_0004);
    wait_idle("bad_next_idle");
    exp_mem[16'h20] = 32'hD00D_0004;
    chk("bad_next_addr", wq_a[wb], 32'h20);
    chk("bad_next_data", wq_d[wb], 32'hD00D_0004);

    // READ len=100 with no pops: response FIFO fills and strobes pause
    rb = rq_a.size();
    wb = wq_a.size();
    push_word(32'h2064_0000);
    n = 0;
    while (status[31:16] != 16'd64 && n < 400) begin
      tick();
      n++;
    end
    repeat (20) tick();
    chk("big_rsp_full", {16'h0, status[31:16]}, 32'd64);
    chk("big_strobes_paused", 32'(rq_a.size() - rb), 32'd64);
    chk("big_state", {28'h0, status[7:4]}, 32'd3);
    // Seventeen zero-length headers while stalled: sixteen fit, one dropped
    for (int i = 0; i < 17; i++) push_word(32'h1000_0000);
    chk("ovf_flag", {31'h0, status[1]}, 32'h1);
    chk("ovf_busy", {31'h0, status[0]}, 32'h1);
    xs = 32'h0;
    for (int i = 0; i < 100; i++) begin
      n = 0;
      while (status[31:16] == 16'd0 && n < 100) begin
        tick();
        n++;
      end
      if (n >= 100) begin
        chk("big_pop_timeout", 32'(i), 32'd100);
        break;
      end
      pop_word(got);
      chk("big_data", got, exp_mem[i]);
      xs ^= exp_mem[i];
    end
`ifdef PIPE_REG_MASTER_CHECKSUM_EN
    n = 0;
    while (status[31:16] == 16'd0 && n < 100) begin
      tick();
      n++;
    end
    pop_word(got);
    chk("big_csum", got, xs);
`endif
    wait_idle("big_idle");
    chk("big_total_strobes", 32'(rq_a.size() - rb), 32'd100);
    nbad = 0;
    for (int i = 0; i < 100; i++) if (rq_a[rb+i] !== 32'(i)) nbad++;
    chk("big_addr_seq", 32'(nbad), 32'd0);
    chk("zero_len_no_write", 32'(wq_a.size() - wb), 32'd0);
    chk("ovf_sticky", {31'h0, status[1]}, 32'h1);

    // Pop from empty response FIFO
    chk("unf_data_before", pipe_out_data, 32'h0);
    pop_word(got);
    chk("unf_data", got, 32'h0);
    chk("unf_flag", {31'h0, status[2]}, 32'h1);
    chk("unf_count", {16'h0, status[31:16]}, 32'd0);

`ifdef PIPE_REG_MASTER_CHECKSUM_EN
    push_word(32'h1003_0040);
    push_word(32'h0000_0001);
    push_word(32'h0000_0002);
    push_word(32'h0000_0004);
    wait_idle("cs_wr_idle");
    push_word(32'h2003_0040);
    wait_idle("cs_rd_idle");
    chk("cs_count", {16'h0, status[31:16]}, 32'd4);
    pop_word(got);
    chk("cs_w0", got, 32'h1);
    pop_word(got);
    chk("cs_w1", got, 32'h2);
    pop_word(got);
    chk("cs_w2", got, 32'h4);
    pop_word(got);
    chk("cs_sum", got, 32'h7);
`endif

    // Reset in the middle of a READ burst
    push_word(32'h2032_0000);
    repeat (8) tick();
    chk("mid_rd_active", {31'h0, regRead}, 32'h1);
    reset_n = 1'b0;
    tick();
    chk("mid_rst_regread", {31'h0, regRead}, 32'h0);
    chk("mid_rst_status", status, 32'h0);
    chk("mid_rst_pipe_out", pipe_out_data, 32'h0);
    reset_n = 1'b1;
    repeat (3) tick();
    chk("post_rst_status", status, 32'h0);
    chk("post_rst_regread", {31'h0, regRead}, 32'h0);

    chk("no_dual_strobe", 32'(both_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire
